// File: rtl/id_exe_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_pipe_stage
// Description : ID/EXE pipeline register with a valid/ready handshake, a
//               one-entry skid buffer, flush, bubble gating and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================

module id_exe_pipe_stage #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int EXE_CMD_LEN  = 4,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    wb_en_in,
    input  logic                    br_taken_in,
    input  logic [EXE_CMD_LEN-1:0]  exe_cmd_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [REG_ADDR_LEN-1:0] src1_in,
    input  logic [REG_ADDR_LEN-1:0] src2_in,
    input  logic [WORD_LEN-1:0]     st_val_in,
    input  logic [WORD_LEN-1:0]     val1_in,
    input  logic [WORD_LEN-1:0]     val2_in,
    input  logic [WORD_LEN-1:0]     pc_in,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    wb_en,
    output logic                    br_taken,
    output logic [EXE_CMD_LEN-1:0]  exe_cmd,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic [REG_ADDR_LEN-1:0] src1,
    output logic [REG_ADDR_LEN-1:0] src2,
    output logic [WORD_LEN-1:0]     st_val,
    output logic [WORD_LEN-1:0]     val1,
    output logic [WORD_LEN-1:0]     val2,
    output logic [WORD_LEN-1:0]     pc,
    output logic [CNT_W-1:0]        stall_cnt
);

    typedef struct packed {
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic                    wb_en;
        logic                    br_taken;
        logic [EXE_CMD_LEN-1:0]  exe_cmd;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [WORD_LEN-1:0]     st_val;
        logic [WORD_LEN-1:0]     val1;
        logic [WORD_LEN-1:0]     val2;
        logic [WORD_LEN-1:0]     pc;
    } entry_t;

    // State bits are {skid valid, main valid}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             m_v;
    logic             in_fire;
    logic             out_fire;

    assign m_v      = state_q[0];
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = m_v & out_ready;

    always_comb begin
        in_entry          = '0;
        in_entry.mem_r_en = mem_r_en_in;
        in_entry.mem_w_en = mem_w_en_in;
        in_entry.wb_en    = wb_en_in;
        in_entry.br_taken = br_taken_in;
        in_entry.exe_cmd  = exe_cmd_in;
        in_entry.dest     = dest_in;
        in_entry.src1     = src1_in;
        in_entry.src2     = src2_in;
        in_entry.st_val   = st_val_in;
        in_entry.val1     = val1_in;
        in_entry.val2     = val2_in;
        in_entry.pc       = pc_in;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_entry;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_ready) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_ready) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d = ~state_d[1];
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_v && !out_ready && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_v;
    // Control fields are forced low during bubbles; data fields are left as-is.
    assign mem_r_en  = main_q.mem_r_en & m_v;
    assign mem_w_en  = main_q.mem_w_en & m_v;
    assign wb_en     = main_q.wb_en    & m_v;
    assign br_taken  = main_q.br_taken & m_v;
    assign exe_cmd   = main_q.exe_cmd;
    assign dest      = main_q.dest;
    assign src1      = main_q.src1;
    assign src2      = main_q.src2;
    assign st_val    = main_q.st_val;
    assign val1      = main_q.val1;
    assign val2      = main_q.val2;
    assign pc        = main_q.pc;
    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_exe_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_pipe_stage
// Description : Self-checking bench: per-cycle vector table plus an in-order
//               scoreboard of accepted instructions.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_id_exe_pipe_stage;

    localparam int WL = 32;
    localparam int RL = 5;
    localparam int CL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, wb_en_in = 1'b0, br_taken_in = 1'b0;
    logic [CL-1:0] exe_cmd_in = '0;
    logic [RL-1:0] dest_in = '0, src1_in = '0, src2_in = '0;
    logic [WL-1:0] st_val_in = '0, val1_in = '0, val2_in = '0, pc_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          mem_r_en, mem_w_en, wb_en, br_taken;
    logic [CL-1:0] exe_cmd;
    logic [RL-1:0] dest, src1, src2;
    logic [WL-1:0] st_val, val1, val2, pc;
    logic [CW-1:0] stall_cnt;

    id_exe_pipe_stage #(
        .WORD_LEN(WL), .REG_ADDR_LEN(RL), .EXE_CMD_LEN(CL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .br_taken_in(br_taken_in),
        .exe_cmd_in(exe_cmd_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .st_val_in(st_val_in), .val1_in(val1_in), .val2_in(val2_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .br_taken(br_taken),
        .exe_cmd(exe_cmd), .dest(dest), .src1(src1), .src2(src2),
        .st_val(st_val), .val1(val1), .val2(val2), .pc(pc),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, fl, iv, ordy, wb, memw;
        logic [31:0] pc_i;
        logic        e_ov, e_ir, e_wb, e_memw, chk_pc;
        logic [31:0] e_pc;
        logic [3:0]  e_st;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        wb, memw;
    } sb_t;

    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mkv(input logic r, f, i, o, w, m, input logic [31:0] p,
                                 input logic eov, eir, ewb, emw, cp, input logic [31:0] ep,
                                 input logic [3:0] est);
        vec_t v;
        v.rst_n = r; v.fl = f; v.iv = i; v.ordy = o; v.wb = w; v.memw = m; v.pc_i = p;
        v.e_ov = eov; v.e_ir = eir; v.e_wb = ewb; v.e_memw = emw; v.chk_pc = cp;
        v.e_pc = ep; v.e_st = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Non-pc payload fields are a fixed function of pc so the scoreboard can rebuild them.
    task automatic set_inputs(input logic [31:0] p, input logic w, input logic m);
        pc_in       = p;
        wb_en_in    = w;
        mem_w_en_in = m;
        mem_r_en_in = p[2];
        br_taken_in = p[3];
        exe_cmd_in  = p[5:2];
        dest_in     = p[6:2];
        src1_in     = p[7:3];
        src2_in     = p[8:4];
        st_val_in   = p ^ 32'hA5A5_5A5A;
        val1_in     = ~p;
        val2_in     = p * 3;
    endtask

    task automatic cycle(input logic r, input logic f, input logic i, input logic o,
                         input logic [31:0] p, input logic w, input logic m);
        sb_t e;
        rst = r; flush = f; in_valid = i; out_ready = o;
        set_inputs(p, w, m);
        #1;
        if (r && out_valid && o) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out_pc", pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_wb_en", {31'd0, wb_en}, {31'd0, e.wb});
                chk("sb_mem_w_en", {31'd0, mem_w_en}, {31'd0, e.memw});
                chk("sb_mem_r_en", {31'd0, mem_r_en}, {31'd0, e.pc[2]});
                chk("sb_br_taken", {31'd0, br_taken}, {31'd0, e.pc[3]});
                chk("sb_exe_cmd", {28'd0, exe_cmd}, {28'd0, e.pc[5:2]});
                chk("sb_dest", {27'd0, dest}, {27'd0, e.pc[6:2]});
                chk("sb_src1", {27'd0, src1}, {27'd0, e.pc[7:3]});
                chk("sb_src2", {27'd0, src2}, {27'd0, e.pc[8:4]});
                chk("sb_st_val", st_val, e.pc ^ 32'hA5A5_5A5A);
                chk("sb_val1", val1, ~e.pc);
                chk("sb_val2", val2, e.pc * 3);
            end
        end
        if (r && i && in_ready && !f) begin
            e.pc = p; e.wb = w; e.memw = m;
            sb_q.push_back(e);
        end
        if (!r || f) sb_q.delete();
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic chk_state(input string tag, input logic eov, input logic eir,
                             input logic [3:0] est);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, eov});
        chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, eir});
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, est});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {28'd0, mem_r_en, mem_w_en, wb_en, br_taken}, 32'd0);
        chk({tag, "_exe_cmd"}, {28'd0, exe_cmd}, 32'd0);
        chk({tag, "_regs"}, {17'd0, dest, src1, src2}, 32'd0);
        chk({tag, "_st_val"}, st_val, 32'd0);
        chk({tag, "_val1"}, val1, 32'd0);
        chk({tag, "_val2"}, val2, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
    endtask

    vec_t tbl[18];

    initial begin
        // rst fl iv or wb mw pc_in | ov ir wb mw chkpc pc st
        tbl[0]  = mkv(0,0,0,1,0,0,32'h00, 0,1,0,0,1,32'h00,4'd0);
        tbl[1]  = mkv(0,0,0,1,0,0,32'h00, 0,1,0,0,1,32'h00,4'd0);
        tbl[2]  = mkv(1,0,0,1,0,0,32'h00, 0,1,0,0,1,32'h00,4'd0);
        tbl[3]  = mkv(1,0,1,1,1,0,32'h00, 1,1,1,0,1,32'h00,4'd0);
        tbl[4]  = mkv(1,0,1,1,1,0,32'h04, 1,1,1,0,1,32'h04,4'd0);
        tbl[5]  = mkv(1,0,1,1,1,0,32'h08, 1,1,1,0,1,32'h08,4'd0);
        tbl[6]  = mkv(1,0,1,1,1,0,32'h0C, 1,1,1,0,1,32'h0C,4'd0);
        tbl[7]  = mkv(1,0,0,1,0,0,32'h00, 0,1,0,0,0,32'h00,4'd0);
        tbl[8]  = mkv(1,0,1,0,1,0,32'h10, 1,1,1,0,1,32'h10,4'd0);
        tbl[9]  = mkv(1,0,1,0,0,0,32'h14, 1,0,1,0,1,32'h10,4'd1);
        tbl[10] = mkv(1,0,0,0,0,0,32'h00, 1,0,1,0,1,32'h10,4'd2);
        tbl[11] = mkv(1,0,0,0,0,0,32'h00, 1,0,1,0,1,32'h10,4'd3);
        tbl[12] = mkv(1,0,0,1,0,0,32'h00, 1,1,0,0,1,32'h14,4'd3);
        tbl[13] = mkv(1,0,0,1,0,0,32'h00, 0,1,0,0,0,32'h00,4'd3);
        tbl[14] = mkv(1,0,1,0,1,1,32'h30, 1,1,1,1,1,32'h30,4'd3);
        tbl[15] = mkv(1,0,1,0,1,0,32'h34, 1,0,1,1,1,32'h30,4'd4);
        tbl[16] = mkv(1,1,1,0,1,1,32'h20, 0,1,0,0,0,32'h00,4'd5);
        tbl[17] = mkv(1,0,0,1,0,0,32'h00, 0,1,0,0,0,32'h00,4'd5);

        @(posedge clk);
        #1;
        for (int k = 0; k < 18; k++) begin
            cycle(tbl[k].rst_n, tbl[k].fl, tbl[k].iv, tbl[k].ordy,
                  tbl[k].pc_i, tbl[k].wb, tbl[k].memw);
            chk_state($sformatf("v%0d", k), tbl[k].e_ov, tbl[k].e_ir, tbl[k].e_st);
            chk($sformatf("v%0d_wb_en", k), {31'd0, wb_en}, {31'd0, tbl[k].e_wb});
            chk($sformatf("v%0d_mem_w_en", k), {31'd0, mem_w_en}, {31'd0, tbl[k].e_memw});
            if (tbl[k].chk_pc) chk($sformatf("v%0d_pc", k), pc, tbl[k].e_pc);
            if (k == 1) chk_all_zero("reset");
            if (k == 13) chk("drained_queue_size", sb_q.size(), 32'd0);
        end

        // Saturation: one held entry, EXE stalled for 20 cycles.
        cycle(1, 0, 1, 0, 32'h40, 1, 0);
        chk_state("sat_load", 1'b1, 1'b1, 4'd5);
        for (int k = 1; k <= 20; k++) begin
            cycle(1, 0, 0, 0, 32'h0, 0, 0);
            chk_state($sformatf("sat%0d", k), 1'b1, 1'b1, (5 + k > 15) ? 4'd15 : 4'(5 + k));
            chk($sformatf("sat%0d_pc", k), pc, 32'h40);
        end
        cycle(1, 1, 0, 0, 32'h0, 0, 0);
        chk_state("sat_flush", 1'b0, 1'b1, 4'd15);
        chk("sat_flush_wb_en", {31'd0, wb_en}, 32'd0);
        cycle(1, 0, 0, 1, 32'h0, 0, 0);
        chk_state("sat_idle", 1'b0, 1'b1, 4'd15);

        // Reset while FULL, with a new instruction offered on the reset edge.
        cycle(1, 0, 1, 0, 32'h50, 1, 1);
        chk_state("rm_one", 1'b1, 1'b1, 4'd15);
        cycle(1, 0, 1, 0, 32'h54, 1, 1);
        chk_state("rm_full", 1'b1, 1'b0, 4'd15);
        cycle(0, 0, 1, 0, 32'h58, 1, 1);
        chk_state("rm_reset", 1'b0, 1'b1, 4'd0);
        chk_all_zero("rm_reset");
        cycle(1, 0, 0, 1, 32'h0, 0, 0);
        chk_state("rm_idle", 1'b0, 1'b1, 4'd0);
        chk_all_zero("rm_idle");

        // After reset the stage must stream normally again.
        cycle(1, 0, 1, 1, 32'h60, 0, 1);
        chk_state("rm_restart", 1'b1, 1'b1, 4'd0);
        chk("rm_restart_pc", pc, 32'h60);
        cycle(1, 0, 0, 1, 32'h0, 0, 0);
        chk("final_queue_size", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
